// File: rtl/food_placer.sv
// food_placer: picks a pseudo-random free playfield cell for the next food item.
// A free-running 10-bit LFSR supplies candidates. Each candidate is range/food
// checked, then compared against every snake segment read from an external
// memory with one-cycle read latency.
//
// Handshake: req is a single-cycle pulse. It is accepted directly in IDLE.
// While busy, it sets a 1-deep pending flag, and further reqs are dropped.
// Every placement ends with exactly one of done (cell committed) or fail
// (tries exhausted), each a one-cycle pulse, and then returns to IDLE.
module food_placer #(
   parameter int MAX_LEN   = 64,
   parameter int GRID_W    = 32,
   parameter int GRID_H    = 24,
   parameter int MAX_TRIES = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [6:0] snake_len,
   output logic [5:0] seg_addr,
   input  logic [4:0] seg_h,
   input  logic [4:0] seg_v,
   output logic [4:0] food_h,
   output logic [4:0] food_v,
   output logic       food_valid,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRAW   = 2'd1;
   localparam logic [1:0] S_SCAN   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   localparam int            TW       = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
   localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);
   localparam logic [5:0]    GW       = 6'(GRID_W);
   localparam logic [5:0]    GH       = 6'(GRID_H);

   logic [1:0]    state_q, state_d;
   logic [9:0]    lfsr_q, lfsr_d;
   logic [6:0]    len_q, len_d;
   logic [6:0]    addr_q, addr_d;
   logic          cmp_vld_q, cmp_vld_d;
   logic          cmp_last_q, cmp_last_d;
   logic [TW-1:0] tries_q, tries_d;
   logic [4:0]    cand_h_q, cand_h_d;
   logic [4:0]    cand_v_q, cand_v_d;
   logic [4:0]    food_h_q, food_h_d;
   logic [4:0]    food_v_q, food_v_d;
   logic          food_valid_q, food_valid_d;
   logic          done_q, done_d;
   logic          fail_q, fail_d;
   logic          pending_q, pending_d;

   logic [4:0] draw_h;
   logic [4:0] draw_v;
   logic       draw_reject;
   logic       seg_hit;
   logic       try_exhausted;
   logic [6:0] len_clamped;
   logic       issuing;

   assign draw_h        = lfsr_q[4:0];
   assign draw_v        = lfsr_q[9:5];
   assign draw_reject   = ({1'b0, draw_h} >= GW) || ({1'b0, draw_v} >= GH) ||
                          (food_valid_q && (draw_h == food_h_q) && (draw_v == food_v_q));
   assign seg_hit       = (seg_h == cand_h_q) && (seg_v == cand_v_q);
   assign try_exhausted = (tries_q == TRY_LAST);
   assign len_clamped   = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
   // A read is issued on every SCAN cycle until all L addresses are out. On the
   // cycle a hit aborts the scan, that speculative read is simply ignored.
   assign issuing       = (state_q == S_SCAN) && (addr_q < len_q);

   assign seg_addr   = issuing ? addr_q[5:0] : 6'd0;
   assign food_h     = food_h_q;
   assign food_v     = food_v_q;
   assign food_valid = food_valid_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign fail       = fail_q;
   assign dbg_state  = state_q;

   // Next-state logic: LFSR stepping, request capture, draw/scan/commit sequencing.
   always_comb begin
      state_d      = state_q;
      lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      len_d        = len_q;
      addr_d       = addr_q;
      cmp_vld_d    = cmp_vld_q;
      cmp_last_d   = cmp_last_q;
      tries_d      = tries_q;
      cand_h_d     = cand_h_q;
      cand_v_d     = cand_v_q;
      food_h_d     = food_h_q;
      food_v_d     = food_v_q;
      food_valid_d = food_valid_q;
      done_d       = 1'b0;
      fail_d       = 1'b0;
      pending_d    = pending_q;

      // Any req seen outside IDLE is remembered once. This includes the
      // COMMIT cycle, so a req that coincides with the done pulse is kept.
      if (req && (state_q != S_IDLE)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (req || pending_q) begin
               state_d   = S_DRAW;
               len_d     = len_clamped;
               tries_d   = '0;
               pending_d = 1'b0;
            end
         end
         S_DRAW: begin
            if (draw_reject) begin
               tries_d = tries_q + TW'(1);
               if (try_exhausted) begin
                  fail_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cand_h_d = draw_h;
               cand_v_d = draw_v;
               if (len_q == 7'd0) begin
                  state_d = S_COMMIT;
               end else begin
                  state_d    = S_SCAN;
                  addr_d     = 7'd0;
                  cmp_vld_d  = 1'b0;
                  cmp_last_d = 1'b0;
               end
            end
         end
         S_SCAN: begin
            if (cmp_vld_q && seg_hit) begin
               cmp_vld_d = 1'b0;
               tries_d   = tries_q + TW'(1);
               if (try_exhausted) begin
                  fail_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAW;
               end
            end else if (cmp_vld_q && cmp_last_q) begin
               cmp_vld_d = 1'b0;
               state_d   = S_COMMIT;
            end else if (issuing) begin
               addr_d     = addr_q + 7'd1;
               cmp_vld_d  = 1'b1;
               cmp_last_d = (addr_q == (len_q - 7'd1));
            end else begin
               cmp_vld_d = 1'b0;
            end
         end
         default: begin
            food_h_d     = cand_h_q;
            food_v_d     = cand_v_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
            state_d      = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lfsr_q       <= 10'h001;
         len_q        <= 7'd0;
         addr_q       <= 7'd0;
         cmp_vld_q    <= 1'b0;
         cmp_last_q   <= 1'b0;
         tries_q      <= '0;
         cand_h_q     <= 5'd0;
         cand_v_q     <= 5'd0;
         food_h_q     <= 5'd0;
         food_v_q     <= 5'd0;
         food_valid_q <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         len_q        <= len_d;
         addr_q       <= addr_d;
         cmp_vld_q    <= cmp_vld_d;
         cmp_last_q   <= cmp_last_d;
         tries_q      <= tries_d;
         cand_h_q     <= cand_h_d;
         cand_v_q     <= cand_v_d;
         food_h_q     <= food_h_d;
         food_v_q     <= food_v_d;
         food_valid_q <= food_valid_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         pending_q    <= pending_d;
      end
   end

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer. A synchronous segment memory answers reads
// one cycle late. In echo mode, it instead returns the cell that the
// free-running LFSR held two cycles earlier, which is the candidate being
// scanned when snake_len=1, so every scan collides.
module tb_food_placer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [6:0] snake_len = 7'd0;
   logic [5:0] seg_addr;
   logic [4:0] seg_h, seg_v;
   logic [4:0] food_h, food_v;
   logic       food_valid, busy, done, fail;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int fail_cnt = 0;
   logic [9:0] first_cell, second_cell;
   logic       echo = 1'b0;
   logic [4:0] mem_h [64];
   logic [4:0] mem_v [64];
   logic [9:0] m_lfsr, m_prev;
   int n;

   food_placer dut (
      .clk(clk), .rst(rst), .req(req), .snake_len(snake_len),
      .seg_addr(seg_addr), .seg_h(seg_h), .seg_v(seg_v),
      .food_h(food_h), .food_v(food_v), .food_valid(food_valid),
      .busy(busy), .done(done), .fail(fail), .dbg_state(dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Reference LFSR, used only to build colliding memory data.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr <= 10'h001;
         m_prev <= 10'h001;
      end else begin
         m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
         m_prev <= m_lfsr;
      end
   end

   // Segment memory with one cycle of read latency.
   always @(posedge clk) begin
      if (echo) begin
         seg_h <= m_prev[4:0];
         seg_v <= m_prev[9:5];
      end else begin
         seg_h <= mem_h[seg_addr];
         seg_v <= mem_v[seg_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge, and tally pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
         if (done_cnt == 0) first_cell = {food_v, food_h};
         else second_cell = {food_v, food_h};
         done_cnt++;
      end
      if (fail === 1'b1) fail_cnt++;
   endtask

   // Tick until done; cnt is the number of edges taken (max if it never came).
   task automatic wait_done(input int max, output int cnt);
      cnt = 0;
      while (cnt < max) begin
         tick();
         cnt++;
         if (done === 1'b1) break;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_h[i] = 5'd31;
         mem_v[i] = 5'd31;
      end
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_food_h", food_h, 0);
      chk("rst_food_v", food_v, 0);
      chk("rst_food_valid", food_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_seg_addr", seg_addr, 0);

      // L=0 right after reset: candidate is the LFSR after 1 step = 0x002 -> (2,0)
      rst = 1'b0;
      req = 1'b1;
      snake_len = 7'd0;
      tick();
      req = 1'b0;
      chk("a_busy_t1", busy, 1);
      tick();
      chk("a_busy_t2", busy, 1);
      chk("a_valid_t2", food_valid, 0);
      tick();
      chk("a_done_t3", done, 1);
      chk("a_food_h", food_h, 2);
      chk("a_food_v", food_v, 0);
      chk("a_valid", food_valid, 1);
      chk("a_busy_t3", busy, 0);

      // L=4, no collision: candidate LFSR 0x010 -> (16,0), done at T+8
      req = 1'b1;
      snake_len = 7'd4;
      tick();
      req = 1'b0;
      snake_len = 7'd0;
      chk("b_draw_addr", seg_addr, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("b_seg_addr", seg_addr, i);
         chk("b_busy", busy, 1);
      end
      tick();
      chk("b_busy_t6", busy, 1);
      tick();
      chk("b_busy_t7", busy, 1);
      chk("b_done_t7", done, 0);
      tick();
      chk("b_done_t8", done, 1);
      chk("b_food_h", food_h, 16);
      chk("b_food_v", food_v, 0);
      chk("b_busy_t8", busy, 0);

      // Segment 2 holds the first candidate (LFSR 0x024 -> (4,1)). The scan aborts,
      // and the redraw (LFSR 0x088 -> (8,4)) commits 7 edges after the redraw.
      mem_h[2] = 5'd4;
      mem_v[2] = 5'd1;
      req = 1'b1;
      snake_len = 7'd4;
      tick();
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("c_seg_addr", seg_addr, i);
      end
      tick();
      tick();
      chk("c_redraw_addr", seg_addr, 0);
      chk("c_redraw_busy", busy, 1);
      chk("c_food_kept_h", food_h, 16);
      wait_done(40, n);
      chk("c_commit_lat", n, 7);
      chk("c_food_h", food_h, 8);
      chk("c_food_v", food_v, 4);
      mem_h[2] = 5'd31;
      mem_v[2] = 5'd31;

      // Every scan collides: exactly one fail pulse, and the food is unchanged.
      done_cnt = 0;
      fail_cnt = 0;
      echo = 1'b1;
      req = 1'b1;
      snake_len = 7'd1;
      tick();
      req = 1'b0;
      n = 0;
      while (fail_cnt == 0 && n < 300) begin
         tick();
         n++;
      end
      repeat (10) tick();
      chk("d_fail_pulses", fail_cnt, 1);
      chk("d_done_pulses", done_cnt, 0);
      chk("d_food_h", food_h, 8);
      chk("d_food_v", food_v, 4);
      chk("d_valid", food_valid, 1);
      chk("d_busy", busy, 0);
      echo = 1'b0;

      // req at T, T+2, T+3: two placements, with the second cell different.
      done_cnt = 0;
      fail_cnt = 0;
      snake_len = 7'd0;
      req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      req = 1'b1;
      tick();
      tick();
      req = 1'b0;
      repeat (150) tick();
      chk("e_done_pulses", done_cnt, 2);
      chk("e_fail_pulses", fail_cnt, 0);
      chk("e_cells_differ", (first_cell != second_cell), 1);
      chk("e_busy", busy, 0);

      // Reset at T+5 of an L=10 placement.
      done_cnt = 0;
      req = 1'b1;
      snake_len = 7'd10;
      tick();
      req = 1'b0;
      repeat (4) tick();
      chk("f_busy_before", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("f_busy", busy, 0);
      chk("f_food_valid", food_valid, 0);
      chk("f_food_h", food_h, 0);
      chk("f_food_v", food_v, 0);
      chk("f_done", done, 0);
      chk("f_fail", fail, 0);
      chk("f_seg_addr", seg_addr, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("f_no_done", done_cnt, 0);

      // After reset, behaves exactly as from power-up.
      rst = 1'b0;
      req = 1'b1;
      snake_len = 7'd0;
      tick();
      req = 1'b0;
      tick();
      tick();
      chk("g_done_t3", done, 1);
      chk("g_food_h", food_h, 2);
      chk("g_food_v", food_v, 0);

      // snake_len=100 clamps to 64: done at T+68 (67 edges after acceptance).
      req = 1'b1;
      snake_len = 7'd100;
      tick();
      req = 1'b0;
      snake_len = 7'd0;
      wait_done(200, n);
      chk("h_clamp_lat", n, 67);
      chk("h_food_h", food_h, 16);
      chk("h_food_v", food_v, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
